// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - flag bit indices, condition codes, opcodes, FSM state and update-mask decode
package flag_pkg;

  localparam int Z_BIT     = 0;
  localparam int V_BIT     = 1;
  localparam int N_BIT     = 2;
  localparam int NUM_FLAGS = 3;

  localparam logic [2:0] CC_NZ = 3'b000;
  localparam logic [2:0] CC_Z  = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_V  = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam logic [3:0] OPC_ADD = 4'b0000;
  localparam logic [3:0] OPC_SUB = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0010;
  localparam logic [3:0] OPC_OR  = 4'b0100;
  localparam logic [3:0] OPC_XOR = 4'b0101;
  localparam logic [3:0] OPC_NOT = 4'b0110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BR_WAIT  = 2'd1,
    SAVE_ACK = 2'd2,
    RST_ACK  = 2'd3
  } state_t;

  // Opcodes wider than 4 bits only match when their upper bits are zero.
  function automatic logic [NUM_FLAGS-1:0] upd_mask(input logic [15:0] opc);
    logic [NUM_FLAGS-1:0] m;
    m = '0;
    case (opc)
      16'(OPC_ADD), 16'(OPC_SUB):                            m = 3'b111;
      16'(OPC_AND), 16'(OPC_OR), 16'(OPC_XOR), 16'(OPC_NOT): m = 3'b001;
      default:                                               m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// rtl/flag_cond_eval.sv - combinational branch condition decode on Z/V/N flags
module flag_cond_eval
  import flag_pkg::*;
(
  input  logic [NUM_FLAGS-1:0] flags,
  input  logic [2:0]           cond,
  output logic                 taken
);

  logic z, v, n;

  always_comb begin
    z = flags[Z_BIT];
    v = flags[V_BIT];
    n = flags[N_BIT];
    taken = 1'b0;
    case (cond)
      CC_NZ:   taken = !z;
      CC_Z:    taken = z;
      CC_GT:   taken = !z && !n;
      CC_LT:   taken = n;
      CC_GE:   taken = z || (!z && !n);
      CC_LE:   taken = n || z;
      CC_V:    taken = v;
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// rtl/flag_ctrl.sv - flag register, shadow save/restore and branch resolve; FLAG_FWD_EN forwards same-cycle updates
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  logic [OPC_W-1:0]  upd_opc,
  input  logic [FLAG_W-1:0] upd_flags,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  output logic              br_taken,
  output logic              br_done,
  input  logic              save_req,
  input  logic              restore_req,
  output logic              ctx_ack,
  output logic [FLAG_W-1:0] flags,
  output logic              stall
);

  state_t            state;
  logic [FLAG_W-1:0] shadow;
  logic [FLAG_W-1:0] mask;
  logic [FLAG_W-1:0] upd_next;
  logic [FLAG_W-1:0] eval_flags;
  logic              ctx_ack_q;
  logic              in_idle;
  logic              restore_go;
  logic              upd_go;
  logic              save_go;
  logic              hazard;
  logic              cond_taken;

  always_comb begin
    in_idle    = (state == IDLE);
    mask       = FLAG_W'(upd_mask(16'(upd_opc)));
    upd_next   = (flags & ~mask) | (upd_flags & mask);
    restore_go = in_idle && restore_req;
    upd_go     = upd_valid && !restore_go;
`ifdef FLAG_FWD_EN
    hazard     = 1'b0;
    eval_flags = (in_idle && upd_go) ? upd_next : flags;
`else
    hazard     = in_idle && br_valid && upd_go && (|mask);
    eval_flags = flags;
`endif
    // A branch hazard takes the cycle ahead of a save; the save is not acknowledged.
    save_go    = in_idle && save_req && !restore_go && !hazard;
  end

  flag_cond_eval u_cond (
    .flags (eval_flags[NUM_FLAGS-1:0]),
    .cond  (br_cond),
    .taken (cond_taken)
  );

  always_comb begin
    br_done  = rst && ((state == BR_WAIT) || (br_valid && !hazard));
    br_taken = br_done && cond_taken;
    stall    = rst && hazard;
    ctx_ack  = ctx_ack_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flags     <= '0;
      shadow    <= '0;
      ctx_ack_q <= 1'b0;
    end else begin
      ctx_ack_q <= 1'b0;
      if (upd_go) flags <= upd_next;
      case (state)
        IDLE: begin
          if (restore_go) begin
            flags     <= shadow;
            state     <= RST_ACK;
            ctx_ack_q <= 1'b1;
          end else if (hazard) begin
            state <= BR_WAIT;
          end else if (save_go) begin
            shadow    <= flags;
            state     <= SAVE_ACK;
            ctx_ack_q <= 1'b1;
          end
        end
        BR_WAIT, SAVE_ACK, RST_ACK: state <= IDLE;
        default:                    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_ctrl.sv
// tb/tb_flag_ctrl.sv - directed self-checking bench for flag_ctrl (honours FLAG_FWD_EN)
module tb_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       upd_valid = 1'b0;
  logic [3:0] upd_opc = '0;
  logic [2:0] upd_flags = '0;
  logic       br_valid = 1'b0;
  logic [2:0] br_cond = '0;
  logic       br_taken, br_done;
  logic       save_req = 1'b0;
  logic       restore_req = 1'b0;
  logic       ctx_ack;
  logic [2:0] flags;
  logic       stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flag_ctrl #(.OPC_W(4), .FLAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_opc(upd_opc), .upd_flags(upd_flags),
    .br_valid(br_valid), .br_cond(br_cond),
    .br_taken(br_taken), .br_done(br_done),
    .save_req(save_req), .restore_req(restore_req),
    .ctx_ack(ctx_ack), .flags(flags), .stall(stall)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    upd_valid = 1'b0; upd_opc = '0; upd_flags = '0;
    br_valid = 1'b0; br_cond = '0;
    save_req = 1'b0; restore_req = 1'b0;
  endtask

  task automatic set_flags(input logic [2:0] v);
    upd_valid = 1'b1; upd_opc = 4'b0000; upd_flags = v;
    step;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    br_valid = 1'b1; br_cond = 3'b111;
    upd_valid = 1'b1; upd_opc = 4'b0000; upd_flags = 3'b111;
    save_req = 1'b1;
    step; step;
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (ctx_ack !== 1'b0) begin failures++; $display("FAIL reset_ctx_ack got=%b exp=0", ctx_ack); end
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL reset_br_done got=%b exp=0", br_done); end
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL reset_br_taken got=%b exp=0", br_taken); end
    clr;
    rst = 1'b1;
  endtask

  task automatic test_update;
    upd_valid = 1'b1; upd_opc = 4'b0001; upd_flags = 3'b101;
    step;
    upd_valid = 1'b0;
    checks++; if (flags !== 3'b101) begin failures++; $display("FAIL upd_all got=%b exp=101", flags); end
  endtask

  task automatic test_mask;
    set_flags(3'b000);
    upd_valid = 1'b1; upd_opc = 4'b0010; upd_flags = 3'b110;
    step;
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL mask_z_only got=%b exp=000", flags); end
    upd_opc = 4'b0011; upd_flags = 3'b111;
    step;
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL mask_none got=%b exp=000", flags); end
    upd_opc = 4'b0110; upd_flags = 3'b111;
    step;
    upd_valid = 1'b0;
    checks++; if (flags !== 3'b001) begin failures++; $display("FAIL mask_z_set got=%b exp=001", flags); end
  endtask

  task automatic test_branch;
    logic [7:0] exp;
    set_flags(3'b001);
    exp = 8'b10110010;
    br_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      br_cond = c[2:0];
      #1;
      checks++;
      if (br_done !== 1'b1 || br_taken !== exp[c]) begin
        failures++;
        $display("FAIL br_f001_c%0d done=%b taken=%b exp_done=1 exp_taken=%b", c, br_done, br_taken, exp[c]);
      end
    end
    br_valid = 1'b0;
    set_flags(3'b110);
    exp = 8'b11101001;
    br_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      br_cond = c[2:0];
      #1;
      checks++;
      if (br_done !== 1'b1 || br_taken !== exp[c]) begin
        failures++;
        $display("FAIL br_f110_c%0d done=%b taken=%b exp_done=1 exp_taken=%b", c, br_done, br_taken, exp[c]);
      end
    end
    br_valid = 1'b0;
    #1;
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL br_idle_done got=%b exp=0", br_done); end
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL br_idle_taken got=%b exp=0", br_taken); end
    step;
  endtask

  task automatic test_hazard;
    set_flags(3'b000);
    br_valid = 1'b1; br_cond = 3'b001;
    upd_valid = 1'b1; upd_opc = 4'b0000; upd_flags = 3'b001;
    #1;
`ifdef FLAG_FWD_EN
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL haz_fwd_stall got=%b exp=0", stall); end
    checks++; if (br_done !== 1'b1 || br_taken !== 1'b1) begin failures++; $display("FAIL haz_fwd_br done=%b taken=%b exp=1/1", br_done, br_taken); end
`else
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL haz_stall got=%b exp=1", stall); end
    checks++; if (br_done !== 1'b0 || br_taken !== 1'b0) begin failures++; $display("FAIL haz_early_br done=%b taken=%b exp=0/0", br_done, br_taken); end
`endif
    step;
    upd_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL haz_next_stall got=%b exp=0", stall); end
    checks++; if (br_done !== 1'b1 || br_taken !== 1'b1) begin failures++; $display("FAIL haz_next_br done=%b taken=%b exp=1/1", br_done, br_taken); end
    br_valid = 1'b0;
    step;
    checks++; if (flags !== 3'b001) begin failures++; $display("FAIL haz_flags got=%b exp=001", flags); end
    br_valid = 1'b1; br_cond = 3'b000;
    upd_valid = 1'b1; upd_opc = 4'b1111; upd_flags = 3'b000;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nohaz_stall got=%b exp=0", stall); end
    checks++; if (br_done !== 1'b1 || br_taken !== 1'b0) begin failures++; $display("FAIL nohaz_br done=%b taken=%b exp=1/0", br_done, br_taken); end
    step;
    clr;
    checks++; if (flags !== 3'b001) begin failures++; $display("FAIL nohaz_flags got=%b exp=001", flags); end
  endtask

  task automatic test_ctx;
    int acks;
    set_flags(3'b100);
    save_req = 1'b1;
    step;
    save_req = 1'b0;
    checks++; if (ctx_ack !== 1'b1) begin failures++; $display("FAIL save_ack got=%b exp=1", ctx_ack); end
    step;
    checks++; if (ctx_ack !== 1'b0) begin failures++; $display("FAIL save_ack_drop got=%b exp=0", ctx_ack); end
    set_flags(3'b011);
    checks++; if (flags !== 3'b011) begin failures++; $display("FAIL ctx_mid_flags got=%b exp=011", flags); end
    restore_req = 1'b1;
    step;
    restore_req = 1'b0;
    checks++; if (flags !== 3'b100) begin failures++; $display("FAIL restore_flags got=%b exp=100", flags); end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (ctx_ack === 1'b1) acks++;
      step;
    end
    checks++; if (acks != 1) begin failures++; $display("FAIL restore_ack_pulses got=%0d exp=1", acks); end
    save_req = 1'b1;
    upd_valid = 1'b1; upd_opc = 4'b0000; upd_flags = 3'b011;
    step;
    clr;
    checks++; if (flags !== 3'b011 || ctx_ack !== 1'b1) begin failures++; $display("FAIL save_upd flags=%b ack=%b exp=011/1", flags, ctx_ack); end
    step;
    restore_req = 1'b1;
    upd_valid = 1'b1; upd_opc = 4'b0000; upd_flags = 3'b111;
    step;
    clr;
    checks++; if (flags !== 3'b100) begin failures++; $display("FAIL restore_over_upd got=%b exp=100", flags); end
    step;
  endtask

  task automatic test_priority;
    int acks;
    set_flags(3'b000);
    save_req = 1'b1;
    step;
    save_req = 1'b0;
    step;
    set_flags(3'b111);
    save_req = 1'b1; restore_req = 1'b1;
    step;
    clr;
    checks++; if (flags !== 3'b000 || ctx_ack !== 1'b1) begin failures++; $display("FAIL restore_wins flags=%b ack=%b exp=000/1", flags, ctx_ack); end
    step;
    set_flags(3'b101);
    restore_req = 1'b1;
    step;
    restore_req = 1'b0;
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL shadow_kept got=%b exp=000", flags); end
    step;
    save_req = 1'b1;
    step;
    save_req = 1'b0;
    rst = 1'b0;
    acks = 0;
    #1;
    if (ctx_ack !== 1'b0) acks++;
    for (int i = 0; i < 2; i++) begin
      step;
      if (ctx_ack !== 1'b0) acks++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      if (ctx_ack !== 1'b0) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL rst_in_ack ack_samples=%0d exp=0", acks); end
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL rst_in_ack_flags got=%b exp=000", flags); end
    set_flags(3'b010);
    checks++; if (flags !== 3'b010) begin failures++; $display("FAIL post_rst_upd got=%b exp=010", flags); end
  endtask

  initial begin
    clr;
    @(posedge clk);
    #1;
    test_reset;
    test_update;
    test_mask;
    test_branch;
    test_hazard;
    test_ctx;
    test_priority;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_ctrl.md
FLAG_CTRL -- requirements
Module: flag_ctrl

Interface
REQ-001 SHALL have parameter OPC_W, default 4, ALU opcode width.
REQ-002 SHALL have parameter FLAG_W, default 3, flag count; bit0=Z, bit1=V, bit2=N.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports upd_valid (input, 1), upd_opc (input, OPC_W) and upd_flags (input, FLAG_W), carrying an ALU flag-update request, its opcode and its candidate flags.
REQ-006 SHALL have ports br_valid (input, 1) and br_cond (input, 3), carrying a branch evaluation request and its condition code.
REQ-007 SHALL have ports br_taken (output, 1) and br_done (output, 1), carrying the branch result and the qualifier for that result.
REQ-008 SHALL have ports save_req (input, 1) and restore_req (input, 1), requesting a flag context save to the shadow register and a restore from it.
REQ-009 SHALL have port ctx_ack  output  1  one-cycle acknowledge for save or restore.
REQ-010 SHALL have ports flags (output, FLAG_W) and stall (output, 1), carrying the architectural flag register and the branch-hold request to the pipeline.

Function
REQ-011 Update mask SHALL be: opc 0000, 0001 -> Z,V,N; opc 0010, 0100, 0101, 0110 -> Z only; all other opcodes -> none.
REQ-012 When upd_valid=1, masked bits of flags SHALL take upd_flags at the next edge; unmasked bits SHALL hold.
REQ-013 br_cond SHALL decode as: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-014 br_taken SHALL be valid only while br_done=1; otherwise it SHALL be 0.
REQ-015 Controller FSM states SHALL be IDLE, BR_WAIT, SAVE_ACK and RST_ACK.
REQ-016 In IDLE, save_req SHALL copy flags into the shadow register and go to SAVE_ACK.
REQ-017 In IDLE, restore_req SHALL load flags from the shadow register and go to RST_ACK.
REQ-018 restore_req SHALL win over save_req when both are asserted in the same cycle.
REQ-019 A restore SHALL override any upd_valid arriving in the same cycle; that update SHALL be dropped.
REQ-020 SAVE_ACK and RST_ACK SHALL assert ctx_ack for exactly one cycle, then return to IDLE; requests arriving in these states SHALL be ignored.
REQ-021 A save SHALL capture pre-update flags when upd_valid is asserted in the same cycle.
REQ-022 A branch on a flag being written in the same cycle SHALL resolve per the FLAG_FWD_EN rules in Configuration.
REQ-023 A branch with no hazard SHALL give br_done=1 combinationally in the request cycle, evaluated on current flags.
REQ-024 br_valid arriving during SAVE_ACK or RST_ACK SHALL be evaluated on the current flags register.

Reset
REQ-025 While rst=0, flags, the shadow register, stall, ctx_ack, br_done and br_taken SHALL all be 0, and the FSM SHALL be in IDLE.
REQ-026 Reset mid-operation (in BR_WAIT or an ACK state) SHALL abandon the operation with no ack and no br_done.
REQ-027 The first active edge after rst deasserts SHALL accept requests normally.

Configuration
REQ-028 With macro FLAG_FWD_EN defined, a same-cycle masked update SHALL be forwarded into branch evaluation: br_done=1 that cycle, stall=0, and BR_WAIT is unused.
REQ-029 Without FLAG_FWD_EN, br_valid with a same-cycle update whose mask is non-zero SHALL assert stall and enter BR_WAIT.
REQ-030 From BR_WAIT, the controller SHALL assert br_done the next cycle on the updated flags, deassert stall and return to IDLE.
REQ-031 The requester SHALL hold br_valid and br_cond stable while stall=1.

Structure
REQ-032 Package flag_pkg SHALL hold flag bit indices, condition-code constants, opcode constants, the FSM state typedef and the mask-decode function.
REQ-033 Condition decode SHALL be sub-module flag_cond_eval, with inputs flags and cond and output taken, purely combinational.

Verification
REQ-034 Bench SHALL reset, then apply upd opc=0001, upd_flags=101, and check flags=101 on the next cycle.
REQ-035 Bench SHALL, with flags=000, apply opc=0010, upd_flags=110, and check flags=000 (only Z is writable and it is 0).
REQ-036 Bench SHALL, with flags=001, apply br_cond=000 and check br_done=1, br_taken=0; with br_cond=101 it SHALL check br_taken=1.
REQ-037 Bench SHALL, with flags=000, apply br_valid, br_cond=001 and upd opc=0000, upd_flags=001 in the same cycle, then check:
  - with FLAG_FWD_EN defined: br_taken=1 that cycle, stall=0;
  - without FLAG_FWD_EN: stall=1, then br_done=1, br_taken=1 one cycle later.
REQ-038 Bench SHALL, with flags=100, save (ctx_ack after 1 cycle), update flags to 011, then restore, and check flags=100 with ctx_ack pulsed once.
REQ-039 Bench SHALL assert save_req and restore_req together with shadow=000 and check that the restore wins (flags=000); it SHALL then drop rst in SAVE_ACK and check that ctx_ack never asserts.
